fetch_sequencer: RTL and testbench

Control-side initiator for the program counter register: generates the write_en / inc / reset strobes that the PC register consumes, and uses the PC value it reads back to fetch instruction words from instruction memory. Fetched words are latched into an instruction register and handed to the decoder over a valid/ack handshake. Jumps are applied through a PC load. Sits between the PC register, instruction memory and the decode stage of the processor datapath.

---
 rtl/fetch_sequencer_if.sv | 34 +++
 rtl/fetch_sequencer.sv | 82 ++++++++
 tb/tb_fetch_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: PC-register, instruction-memory and decode-side signals of the fetch sequencer
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               start;
    logic [ADDR_W-1:0]  pc_value;
    logic               pc_reset;
    logic               pc_write_en;
    logic               pc_inc;
    logic [ADDR_W-1:0]  pc_datain;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ready;
    logic [INSTR_W-1:0] mem_rdata;
    logic [INSTR_W-1:0] ir_out;
    logic               ir_valid;
    logic               ir_ack;
    logic               jump_req;
    logic [ADDR_W-1:0]  jump_addr;
    logic               halt_req;
    logic               busy;
    logic               timeout_err;
    modport master (
        input  start, pc_value, mem_ready, mem_rdata, ir_ack, jump_req, jump_addr, halt_req,
        output pc_reset, pc_write_en, pc_inc, pc_datain, mem_req, mem_addr, ir_out, ir_valid,
               busy, timeout_err
    );
    modport slave (
        output start, pc_value, mem_ready, mem_rdata, ir_ack, jump_req, jump_addr, halt_req,
        input  pc_reset, pc_write_en, pc_inc, pc_datain, mem_req, mem_addr, ir_out, ir_valid,
               busy, timeout_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives PC register strobes, fetches instructions and hands them to decode
module fetch_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 15
) (
    input logic clk,
    input logic reset,
    fetch_sequencer_if.master bus
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] PC_CLR     = 3'd1;
    localparam logic [2:0] FETCH_REQ  = 3'd2;
    localparam logic [2:0] FETCH_WAIT = 3'd3;
    localparam logic [2:0] HOLD       = 3'd4;
    localparam logic [2:0] PC_UPD     = 3'd5;
    localparam logic [2:0] HALTED     = 3'd6;
    localparam logic [2:0] ERROR      = 3'd7;
    localparam logic [7:0] LAST       = 8'(TIMEOUT - 1);
    logic [2:0]         state;
    logic [7:0]         cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  jaddr_q;
    logic [INSTR_W-1:0] ir_q;
    logic               jmp_q;
    logic               hlt_q;
    logic               err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            jaddr_q <= '0;
            ir_q    <= '0;
            jmp_q   <= 1'b0;
            hlt_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE:      state <= bus.start ? PC_CLR : IDLE;
                PC_CLR:    state <= FETCH_REQ;
                FETCH_REQ: begin
                    addr_q <= bus.pc_value;
                    cnt    <= '0;
                    state  <= FETCH_WAIT;
                end
                // a ready arriving on the last allowed cycle still wins over the timeout
                FETCH_WAIT: begin
                    if (bus.mem_ready) begin
                        ir_q  <= bus.mem_rdata;
                        state <= HOLD;
                    end else if (cnt == LAST) begin
                        err_q <= 1'b1;
                        state <= ERROR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (bus.ir_ack) begin
                        jmp_q <= bus.jump_req;
                        hlt_q <= bus.halt_req;
                        if (bus.jump_req) jaddr_q <= bus.jump_addr;
                        state <= PC_UPD;
                    end
                end
                PC_UPD:  state <= hlt_q ? HALTED : FETCH_REQ;
                default: state <= state;
            endcase
        end
    end
    assign bus.pc_reset    = state == PC_CLR;
    assign bus.pc_write_en = state == PC_UPD && jmp_q;
    assign bus.pc_inc      = state == PC_UPD && !jmp_q;
    assign bus.pc_datain   = jaddr_q;
    assign bus.mem_req     = state == FETCH_REQ || state == FETCH_WAIT;
    assign bus.mem_addr    = state == FETCH_REQ ? bus.pc_value : addr_q;
    assign bus.ir_out      = ir_q;
    assign bus.ir_valid    = state == HOLD;
    assign bus.busy        = !(state == IDLE || state == HALTED || state == ERROR);
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized fetch/ack/jump/halt traffic against a per-cycle expected trace
module tb_fetch_sequencer;
    localparam int TO = 15;
    typedef struct packed {
        logic        rst, start, ready, ack, jreq, halt;
        logic [15:0] rdata, jaddr;
        logic        chk, full, prst, we, inc, req, irv, busy, terr;
        logic [15:0] din, addr, ir;
    } cyc_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [15:0] pc = 16'hBEEF;
    cyc_t c;
    cyc_t iq[$];
    cyc_t eq[$];
    int n_vec = 0, n_err = 0, cyc = 0, req_cyc = 0, lat = 0;
    int n_inc = 0, n_we = 0, n_prst = 0, n_reqc = 0;
    logic [15:0] p = 16'h0;
    logic terr = 1'b0;
    logic prev_req = 1'b0, prev_irv = 1'b0;

    fetch_sequencer_if #(.ADDR_W(16), .INSTR_W(16)) bus ();
    fetch_sequencer #(.ADDR_W(16), .INSTR_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );

    always #5 clk = ~clk;
    assign bus.pc_value = pc;
    // the PC register the sequencer controls
    always @(posedge clk)
        pc <= bus.pc_reset ? 16'h0 : bus.pc_write_en ? bus.pc_datain : bus.pc_inc ? pc + 16'h1 : pc;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return 16'h1234 + a * 16'h0101;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc_t e;
        cyc++;
        if (eq.size() > 0) begin
            e = eq.pop_front();
            if (e.chk) begin
                check("pc_reset", 16'(bus.pc_reset), 16'(e.prst));
                check("pc_write_en", 16'(bus.pc_write_en), 16'(e.we));
                check("pc_inc", 16'(bus.pc_inc), 16'(e.inc));
                check("mem_req", 16'(bus.mem_req), 16'(e.req));
                check("ir_valid", 16'(bus.ir_valid), 16'(e.irv));
                check("busy", 16'(bus.busy), 16'(e.busy));
                check("timeout_err", 16'(bus.timeout_err), 16'(e.terr));
                if (e.req || e.full) check("mem_addr", bus.mem_addr, e.addr);
                if (e.irv || e.full) check("ir_out", bus.ir_out, e.ir);
                if (e.we || e.full) check("pc_datain", bus.pc_datain, e.din);
                if (bus.pc_inc === 1'b1) n_inc++;
                if (bus.pc_write_en === 1'b1) n_we++;
                if (bus.pc_reset === 1'b1) n_prst++;
                if (bus.mem_req === 1'b1) n_reqc++;
                if (bus.mem_req === 1'b1 && prev_req !== 1'b1) req_cyc = cyc;
                if (bus.ir_valid === 1'b1 && prev_irv !== 1'b1) lat = cyc - req_cyc;
                prev_req = bus.mem_req;
                prev_irv = bus.ir_valid;
            end
        end
    end

    task automatic blank();
        c = '0;
        c.chk = 1'b1;
        c.start = 1'b1;
        c.terr = terr;
        c.rdata = 16'($urandom);
        c.jaddr = 16'($urandom);
    endtask

    task automatic emit();
        iq.push_back(c);
        eq.push_back(c);
    endtask

    task automatic do_reset();
        blank();
        c.rst = 1'b1;
        c.chk = 1'b0;
        emit();
        terr = 1'b0;
    endtask

    task automatic start_run(input int n);
        for (int i = 0; i < n; i++) begin
            blank();
            c.start = 1'b0;
            c.full = 1'b1;
            c.ready = 1'($urandom);
            c.ack = 1'($urandom);
            emit();
        end
        blank();
        c.full = 1'b1;
        emit();
        blank();
        c.prst = 1'b1;
        c.busy = 1'b1;
        emit();
        p = 16'h0;
    endtask

    // one instruction: request, w empty waits, ready, a idle hold cycles, ack, PC update
    task automatic fetch(input int w, input int a, input logic j, input logic h,
                         input logic [15:0] ja, output logic stop);
        stop = 1'b0;
        blank(); c.req = 1'b1; c.addr = p; c.busy = 1'b1; c.ack = 1'($urandom); emit();
        for (int i = 0; i < w && i < TO; i++) begin
            blank(); c.req = 1'b1; c.addr = p; c.busy = 1'b1;
            c.ack = 1'($urandom); c.jreq = 1'($urandom); c.halt = 1'($urandom);
            emit();
        end
        if (w >= TO) begin
            terr = 1'b1;
            stop = 1'b1;
            return;
        end
        blank(); c.req = 1'b1; c.addr = p; c.busy = 1'b1; c.ready = 1'b1; c.rdata = mem_f(p); emit();
        for (int i = 0; i <= a; i++) begin
            blank(); c.irv = 1'b1; c.ir = mem_f(p); c.busy = 1'b1; c.ready = 1'($urandom);
            if (i == a) begin
                c.ack = 1'b1; c.jreq = j; c.jaddr = ja; c.halt = h;
            end else begin
                c.jreq = 1'($urandom); c.halt = 1'($urandom);
            end
            emit();
        end
        blank(); c.busy = 1'b1; c.we = j; c.inc = !j; c.din = j ? ja : 16'h0;
        c.ack = 1'($urandom); c.ready = 1'($urandom);
        emit();
        p = j ? ja : p + 16'h1;
        stop = h;
    endtask

    task automatic park(input int n);
        for (int i = 0; i < n; i++) begin
            blank(); c.ready = 1'($urandom); c.ack = 1'($urandom); c.jreq = 1'($urandom);
            emit();
        end
    endtask

    task automatic abort(input int k);
        blank(); c.req = 1'b1; c.addr = p; c.busy = 1'b1; emit();
        for (int i = 0; i < k; i++) begin
            blank(); c.req = 1'b1; c.addr = p; c.busy = 1'b1; emit();
        end
        blank(); c.req = 1'b1; c.addr = p; c.busy = 1'b1; c.rst = 1'b1; emit();
        terr = 1'b0;
        blank(); c.full = 1'b1; c.start = 1'b0; c.ready = 1'b1; c.rdata = 16'hFFFF; emit();
        for (int i = 0; i < 2; i++) begin
            blank(); c.full = 1'b1; c.start = 1'b0; emit();
        end
    endtask

    task automatic run();
        cyc_t d;
        while (iq.size() > 0) begin
            @(negedge clk);
            d = iq.pop_front();
            reset = d.rst;
            bus.start = d.start;
            bus.mem_ready = d.ready;
            bus.mem_rdata = d.rdata;
            bus.ir_ack = d.ack;
            bus.jump_req = d.jreq;
            bus.jump_addr = d.jaddr;
            bus.halt_req = d.halt;
        end
        #1;
    endtask

    initial begin
        logic stop;
        bus.start = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = '0; bus.ir_ack = 1'b0;
        bus.jump_req = 1'b0; bus.jump_addr = '0; bus.halt_req = 1'b0;
        // sequential fetches, a jump to 0x00A0, then halt there
        do_reset(); start_run(2);
        for (int i = 0; i < 3; i++) fetch(0, 0, 1'b0, 1'b0, 16'h0, stop);
        fetch(0, 1, 1'b1, 1'b0, 16'h00A0, stop);
        fetch(0, 0, 1'b0, 1'b1, 16'h0, stop);
        park(5);
        run();
        check("first_latency", 16'(lat), 16'd2);
        check("inc_pulses", 16'(n_inc), 16'd4);
        check("write_pulses", 16'(n_we), 16'd1);
        check("clr_pulses", 16'(n_prst), 16'd1);
        check("pc_final", pc, 16'h00A1);
        check("ir_final", bus.ir_out, 16'hB2D4);
        check("busy_halted", 16'(bus.busy), 16'd0);
        check("req_halted", 16'(bus.mem_req), 16'd0);
        // ready on the last allowed wait cycle, then a real timeout
        n_reqc = 0;
        do_reset(); start_run(0);
        fetch(TO - 1, 0, 1'b0, 1'b0, 16'h0, stop);
        fetch(TO + 5, 0, 1'b0, 1'b0, 16'h0, stop);
        park(4);
        run();
        check("req_cycles", 16'(n_reqc), 16'd32);
        check("timeout_sticky", 16'(bus.timeout_err), 16'd1);
        check("req_error", 16'(bus.mem_req), 16'd0);
        check("busy_error", 16'(bus.busy), 16'd0);
        // reset in the middle of a wait, with a late ready
        do_reset(); start_run(1); abort(3);
        run();
        check("irv_abort", 16'(bus.ir_valid), 16'd0);
        check("ir_abort", bus.ir_out, 16'h0);
        check("busy_abort", 16'(bus.busy), 16'd0);
        for (int r = 0; r < 12; r++) begin
            int n;
            do_reset(); start_run($urandom_range(0, 3));
            n = $urandom_range(1, 8);
            stop = 1'b0;
            for (int i = 0; i < n && !stop; i++) begin
                int w;
                logic [15:0] ja;
                w = ($urandom % 8 == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
                ja = ($urandom % 3 == 0) ? 16'hFFFF : 16'($urandom);
                fetch(w, $urandom_range(0, 3), 1'($urandom % 4 == 0), 1'(i == n - 1 && $urandom % 2 == 1), ja, stop);
            end
            if (stop) park(3);
            run();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
